// File: rtl/ball_motion_ctrl_if.sv
// Bus bundle for the ball motion sequencer: vsync and key inputs, ball
// position and status outputs. Clock and reset stay as plain ports.
interface ball_motion_ctrl_if #(
   parameter int COORD_W = 11
);
   logic               i_vga_vs;
   logic               i_key_0;
   logic               i_key_1;
   logic               i_key_2;
   logic [COORD_W-1:0] o_cx;
   logic [COORD_W-1:0] o_cy;
   logic               o_dir_x;
   logic               o_dir_y;
   logic [2:0]         o_speed;
   logic               o_paused;
   logic               o_busy;
   logic               o_step_done;

   modport master (
      output i_vga_vs, i_key_0, i_key_1, i_key_2,
      input  o_cx, o_cy, o_dir_x, o_dir_y, o_speed, o_paused, o_busy, o_step_done
   );

   modport slave (
      input  i_vga_vs, i_key_0, i_key_1, i_key_2,
      output o_cx, o_cy, o_dir_x, o_dir_y, o_speed, o_paused, o_busy, o_step_done
   );
endinterface

// File: rtl/ball_motion_ctrl.sv
// Frame-synchronous ball motion sequencer: one position step per
// FRAMES_PER_STEP vsync falling edges, per-axis bounce at the travel limits,
// key-driven speed up/down and pause toggle.
module ball_motion_ctrl #(
   parameter int COORD_W         = 11,
   parameter int H_ACTIVE        = 640,
   parameter int V_ACTIVE        = 480,
   parameter int X_MIN           = 30,
   parameter int X_MAX           = 610,
   parameter int Y_MIN           = 30,
   parameter int Y_MAX           = 450,
   parameter int FRAMES_PER_STEP = 1,
   parameter int MAX_SPEED       = 7
) (
   input  logic              i_clk,
   input  logic              i_rst,
   ball_motion_ctrl_if.slave bus
);

   localparam int CW1   = COORD_W + 1;
   localparam int DIV_W = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
   localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(FRAMES_PER_STEP - 1);
   localparam logic [CW1-1:0]     X_LO     = CW1'(X_MIN);
   localparam logic [CW1-1:0]     X_HI     = CW1'(X_MAX);
   localparam logic [CW1-1:0]     Y_LO     = CW1'(Y_MIN);
   localparam logic [CW1-1:0]     Y_HI     = CW1'(Y_MAX);
   localparam logic [2:0]         SPD_MAX  = 3'(MAX_SPEED);
   localparam logic [COORD_W-1:0] X_RST    = COORD_W'(H_ACTIVE / 2);
   localparam logic [COORD_W-1:0] Y_RST    = COORD_W'(V_ACTIVE / 2);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STEP_X = 2'd1,
      STEP_Y = 2'd2,
      COMMIT = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic [3:0]         sync1_q, sync2_q, sync_d_q;
   logic [3:0]         fall;
   logic               tick, ev_up, ev_dn, ev_pause;
   logic [2:0]         speed_q, spd_lat_q;
   logic               paused_q;
   logic [DIV_W-1:0]   div_q;
   logic [COORD_W-1:0] cx_q, cy_q, nx_q;
   logic               dir_x_q, dir_y_q;
   logic               start, div_inc, busy, step_done;
   logic [COORD_W-1:0] nx_calc, ny_calc;
   logic               dx_next, dy_next;

   // One bounded step along an axis; returns {next_dir, next_pos}.
   // Landing exactly on a limit counts as a bounce.
   function automatic logic [CW1-1:0] axis_step(
      input logic [COORD_W-1:0] pos,
      input logic               dir,
      input logic [CW1-1:0]     lo,
      input logic [CW1-1:0]     hi,
      input logic [2:0]         spd
   );
      logic [CW1-1:0] p, s, sum;
      p   = {1'b0, pos};
      s   = CW1'(spd);
      sum = p + s;
      if (dir) begin
         if (sum >= hi) axis_step = {1'b0, hi[COORD_W-1:0]};
         else           axis_step = {1'b1, sum[COORD_W-1:0]};
      end else begin
         if (p <= lo + s) axis_step = {1'b1, lo[COORD_W-1:0]};
         else             axis_step = {1'b0, pos - COORD_W'(spd)};
      end
   endfunction

   // Two-flop synchronisers plus a delay stage for falling-edge detection,
   // bit order {key_2, key_1, key_0, vsync}; all idle high.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         sync1_q  <= '1;
         sync2_q  <= '1;
         sync_d_q <= '1;
      end else begin
         sync1_q  <= {bus.i_key_2, bus.i_key_1, bus.i_key_0, bus.i_vga_vs};
         sync2_q  <= sync1_q;
         sync_d_q <= sync2_q;
      end
   end

   assign fall     = sync_d_q & ~sync2_q;
   assign tick     = fall[0];
   assign ev_up    = fall[1];
   assign ev_dn    = fall[2];
   assign ev_pause = fall[3];

   // Key handling runs in every FSM state; simultaneous up/down cancels.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         speed_q  <= 3'd1;
         paused_q <= 1'b0;
      end else begin
         if (ev_up && !ev_dn && speed_q < SPD_MAX)
            speed_q <= speed_q + 3'd1;
         else if (ev_dn && !ev_up && speed_q > 3'd1)
            speed_q <= speed_q - 3'd1;
         if (ev_pause)
            paused_q <= ~paused_q;
      end
   end

   // Sequencer state register.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Next-state and control decode; ticks outside IDLE are dropped.
   always_comb begin
      state_d   = state_q;
      start     = 1'b0;
      div_inc   = 1'b0;
      busy      = 1'b0;
      step_done = 1'b0;
      case (state_q)
         IDLE: begin
            if (tick && !paused_q) begin
               if (div_q == DIV_LAST) begin
                  start   = 1'b1;
                  state_d = STEP_X;
               end else begin
                  div_inc = 1'b1;
               end
            end
         end
         STEP_X: begin
            busy    = 1'b1;
            state_d = STEP_Y;
         end
         STEP_Y: begin
            busy    = 1'b1;
            state_d = COMMIT;
         end
         COMMIT: begin
            busy      = 1'b1;
            step_done = 1'b1;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Per-axis step arithmetic on the latched speed.
   always_comb begin
      {dx_next, nx_calc} = axis_step(cx_q, dir_x_q, X_LO, X_HI, spd_lat_q);
      {dy_next, ny_calc} = axis_step(cy_q, dir_y_q, Y_LO, Y_HI, spd_lat_q);
   end

   // Frame divider, speed latch and position/direction registers.
   // x is staged in nx_q and written together with y on the STEP_Y->COMMIT
   // edge, so both coordinates read new exactly while step_done is high.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         div_q     <= '0;
         spd_lat_q <= 3'd1;
         nx_q      <= '0;
         cx_q      <= X_RST;
         cy_q      <= Y_RST;
         dir_x_q   <= 1'b1;
         dir_y_q   <= 1'b1;
      end else begin
         if (start) begin
            div_q     <= '0;
            spd_lat_q <= speed_q;
         end else if (div_inc) begin
            div_q <= div_q + 1'b1;
         end
         if (state_q == STEP_X) begin
            nx_q    <= nx_calc;
            dir_x_q <= dx_next;
         end
         if (state_q == STEP_Y) begin
            cx_q    <= nx_q;
            cy_q    <= ny_calc;
            dir_y_q <= dy_next;
         end
      end
   end

   assign bus.o_cx        = cx_q;
   assign bus.o_cy        = cy_q;
   assign bus.o_dir_x     = dir_x_q;
   assign bus.o_dir_y     = dir_y_q;
   assign bus.o_speed     = speed_q;
   assign bus.o_paused    = paused_q;
   assign bus.o_busy      = busy;
   assign bus.o_step_done = step_done;

endmodule

// File: tb/tb_ball_motion_ctrl.sv
// Bench for ball_motion_ctrl: three instances (default, FRAMES_PER_STEP=4,
// start next to the right wall) share one stimulus stream and are compared
// against a per-instance arithmetic model of the ball.
module tb_ball_motion_ctrl;
   localparam int CW = 11;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic vs  = 1'b1;
   logic k0  = 1'b1;
   logic k1  = 1'b1;
   logic k2  = 1'b1;

   always #5 clk = ~clk;

   ball_motion_ctrl_if #(.COORD_W(CW)) b0 ();
   ball_motion_ctrl_if #(.COORD_W(CW)) b1 ();
   ball_motion_ctrl_if #(.COORD_W(CW)) b2 ();

   assign b0.i_vga_vs = vs; assign b0.i_key_0 = k0; assign b0.i_key_1 = k1; assign b0.i_key_2 = k2;
   assign b1.i_vga_vs = vs; assign b1.i_key_0 = k0; assign b1.i_key_1 = k1; assign b1.i_key_2 = k2;
   assign b2.i_vga_vs = vs; assign b2.i_key_0 = k0; assign b2.i_key_1 = k1; assign b2.i_key_2 = k2;

   ball_motion_ctrl #(.COORD_W(CW)) u_dut (.i_clk(clk), .i_rst(rst), .bus(b0));
   ball_motion_ctrl #(.COORD_W(CW), .FRAMES_PER_STEP(4)) u_fps4 (.i_clk(clk), .i_rst(rst), .bus(b1));
   ball_motion_ctrl #(.COORD_W(CW), .H_ACTIVE(1218)) u_edge (.i_clk(clk), .i_rst(rst), .bus(b2));

   int total = 0;
   int bad   = 0;

   // observed outputs
   int cx_o[3], cy_o[3], dx_o[3], dy_o[3], sp_o[3], ps_o[3], by_o[3], dn_o[3];

   // reference model
   int fps[3] = '{1, 4, 1};
   int x0[3]  = '{320, 320, 609};
   int m_x[3], m_y[3], m_dx[3], m_dy[3], m_spd[3], m_ps[3], m_div[3];
   int pulse_tot[3];

   task automatic check(input string tag, input int got, input int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic snap();
      cx_o[0] = int'(b0.o_cx); cy_o[0] = int'(b0.o_cy); dx_o[0] = int'(b0.o_dir_x); dy_o[0] = int'(b0.o_dir_y);
      sp_o[0] = int'(b0.o_speed); ps_o[0] = int'(b0.o_paused); by_o[0] = int'(b0.o_busy); dn_o[0] = int'(b0.o_step_done);
      cx_o[1] = int'(b1.o_cx); cy_o[1] = int'(b1.o_cy); dx_o[1] = int'(b1.o_dir_x); dy_o[1] = int'(b1.o_dir_y);
      sp_o[1] = int'(b1.o_speed); ps_o[1] = int'(b1.o_paused); by_o[1] = int'(b1.o_busy); dn_o[1] = int'(b1.o_step_done);
      cx_o[2] = int'(b2.o_cx); cy_o[2] = int'(b2.o_cy); dx_o[2] = int'(b2.o_dir_x); dy_o[2] = int'(b2.o_dir_y);
      sp_o[2] = int'(b2.o_speed); ps_o[2] = int'(b2.o_paused); by_o[2] = int'(b2.o_busy); dn_o[2] = int'(b2.o_step_done);
   endtask

   task automatic mdl_reset();
      for (int i = 0; i < 3; i++) begin
         m_x[i] = x0[i]; m_y[i] = 240; m_dx[i] = 1; m_dy[i] = 1;
         m_spd[i] = 1; m_ps[i] = 0; m_div[i] = 0;
      end
   endtask

   // returns 1 when this frame tick starts a step
   function automatic bit mdl_tick(input int i);
      if (m_ps[i] != 0) return 1'b0;
      if (m_div[i] == fps[i] - 1) begin
         m_div[i] = 0;
         return 1'b1;
      end
      m_div[i]++;
      return 1'b0;
   endfunction

   task automatic move_axis(inout int pos, inout int dir, input int lo, input int hi, input int s);
      if (dir != 0) begin
         if (pos + s >= hi) begin pos = hi; dir = 0; end
         else pos = pos + s;
      end else begin
         if (pos - s <= lo) begin pos = lo; dir = 1; end
         else pos = pos - s;
      end
   endtask

   task automatic mdl_move(input int i);
      move_axis(m_x[i], m_dx[i], 30, 610, m_spd[i]);
      move_axis(m_y[i], m_dy[i], 30, 450, m_spd[i]);
   endtask

   task automatic mdl_key(input bit up, input bit dn, input bit pz);
      for (int i = 0; i < 3; i++) begin
         if (up && !dn && m_spd[i] < 7) m_spd[i]++;
         if (dn && !up && m_spd[i] > 1) m_spd[i]--;
         if (pz) m_ps[i] = 1 - m_ps[i];
      end
   endtask

   task automatic check_state(input string tag);
      snap();
      for (int i = 0; i < 3; i++) begin
         check($sformatf("%s_cx%0d", tag, i), cx_o[i], m_x[i]);
         check($sformatf("%s_cy%0d", tag, i), cy_o[i], m_y[i]);
         check($sformatf("%s_dx%0d", tag, i), dx_o[i], m_dx[i]);
         check($sformatf("%s_dy%0d", tag, i), dy_o[i], m_dy[i]);
         check($sformatf("%s_spd%0d", tag, i), sp_o[i], m_spd[i]);
         check($sformatf("%s_pause%0d", tag, i), ps_o[i], m_ps[i]);
         check($sformatf("%s_busy%0d", tag, i), by_o[i], 0);
         check($sformatf("%s_done%0d", tag, i), dn_o[i], 0);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      vs = 1'b1; k0 = 1'b1; k1 = 1'b1; k2 = 1'b1;
      mdl_reset();
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check_state("rst");
   endtask

   // key: 0 up, 1 down, 2 pause, 3 up+down together
   task automatic press(input int key);
      mdl_key(key == 0 || key == 3, key == 1 || key == 3, key == 2);
      k0 = !(key == 0 || key == 3);
      k1 = !(key == 1 || key == 3);
      k2 = !(key == 2);
      repeat (2) @(negedge clk);
      k0 = 1'b1; k1 = 1'b1; k2 = 1'b1;
      repeat (4) @(negedge clk);
      check_state("key");
   endtask

   // One vsync pulse (dbl: a second falling edge while the step is in flight),
   // optionally with a key event that lands during the step. Fixed window.
   task automatic frame(input bit dbl, input int key);
      int old_x[3], old_y[3], pulses[3], busy[3], lat[3], lat_exp[3];
      int xat[3], yat[3], pre_x[3], pre_y[3];
      bit stp[3];
      for (int i = 0; i < 3; i++) begin
         old_x[i] = m_x[i]; old_y[i] = m_y[i];
         pulses[i] = 0; busy[i] = 0; lat[i] = -1; lat_exp[i] = 5;
         xat[i] = -1; yat[i] = -1; pre_x[i] = -1; pre_y[i] = -1;
         stp[i] = mdl_tick(i);
         if (!stp[i] && dbl) begin
            stp[i] = mdl_tick(i);
            lat_exp[i] = 7;
         end
         if (stp[i]) mdl_move(i);
      end
      if (key >= 0) mdl_key(key == 0 || key == 3, key == 1 || key == 3, key == 2);
      vs = 1'b0;
      for (int s = 1; s <= 14; s++) begin
         @(posedge clk);
         @(negedge clk);
         snap();
         for (int i = 0; i < 3; i++) begin
            if (dn_o[i] != 0) begin
               pulses[i]++;
               if (lat[i] < 0) begin lat[i] = s; xat[i] = cx_o[i]; yat[i] = cy_o[i]; end
            end
            if (by_o[i] != 0) busy[i]++;
            if (s == 4) begin pre_x[i] = cx_o[i]; pre_y[i] = cy_o[i]; end
         end
         if (dbl) vs = (s == 1) || (s >= 4);
         else     vs = (s >= 3);
         if (key >= 0 && s == 2) begin
            k0 = !(key == 0 || key == 3);
            k1 = !(key == 1 || key == 3);
            k2 = !(key == 2);
         end
         if (s == 4) begin k0 = 1'b1; k1 = 1'b1; k2 = 1'b1; end
      end
      for (int i = 0; i < 3; i++) begin
         pulse_tot[i] += pulses[i];
         check($sformatf("frm_pulses%0d", i), pulses[i], int'(stp[i]));
         check($sformatf("frm_busy%0d", i), busy[i], stp[i] ? 3 : 0);
         check($sformatf("frm_prex%0d", i), pre_x[i], old_x[i]);
         check($sformatf("frm_prey%0d", i), pre_y[i], old_y[i]);
         if (stp[i]) begin
            check($sformatf("frm_lat%0d", i), lat[i], lat_exp[i]);
            check($sformatf("frm_xat%0d", i), xat[i], m_x[i]);
            check($sformatf("frm_yat%0d", i), yat[i], m_y[i]);
         end
      end
      check_state("frm");
   endtask

   initial begin
      int saved, seen, r;
      mdl_reset();
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check_state("init");
      check("init_cx", cx_o[0], 320);
      check("init_cy", cy_o[0], 240);

      // first step from reset; frame divider of 4
      for (int i = 0; i < 3; i++) pulse_tot[i] = 0;
      for (int n = 1; n <= 8; n++) begin
         frame(1'b0, -1);
         if (n == 1) begin
            check("t1_cx", cx_o[0], 321);
            check("t1_cy", cy_o[0], 241);
         end
         if (n == 4) check("t5_cx4", cx_o[1], 321);
      end
      check("t5_cx8", cx_o[1], 322);
      check("t5_pulses", pulse_tot[1], 2);

      // bounce off the right wall at speed 3
      do_reset();
      press(0);
      press(0);
      frame(1'b0, -1);
      check("t2_cx_wall", cx_o[2], 610);
      check("t2_dir", dx_o[2], 0);
      frame(1'b0, -1);
      check("t2_cx_back", cx_o[2], 607);

      // speed saturation both ways and cancelling keys
      for (int n = 0; n < 8; n++) press(0);
      check("t3_max", sp_o[0], 7);
      press(3);
      check("t3_both", sp_o[0], 7);
      for (int n = 0; n < 10; n++) press(1);
      check("t3_min", sp_o[0], 1);

      // pause freezes motion, unpause resumes
      saved = cx_o[0];
      press(2);
      for (int n = 0; n < 5; n++) frame(1'b0, -1);
      check("t4_paused", ps_o[0], 1);
      check("t4_frozen", cx_o[0], saved);
      press(2);
      frame(1'b0, -1);
      check("t4_resume", cx_o[0], saved + 1);

      // tick while busy, keys while busy
      frame(1'b1, -1);
      frame(1'b0, 0);
      frame(1'b0, 1);
      frame(1'b0, 2);
      frame(1'b0, -1);
      press(2);

      // randomized mix
      repeat (80) begin
         r = $urandom_range(0, 9);
         case (r)
            5:       frame(1'b0, int'($urandom_range(0, 1)));
            6:       press(0);
            7:       press(1);
            8:       press(3);
            9:       if ($urandom_range(0, 3) == 0) press(2); else frame(1'b1, -1);
            default: frame(1'b0, -1);
         endcase
      end

      // reset in the middle of a step
      do_reset();
      vs = 1'b0;
      repeat (4) @(negedge clk);
      snap();
      check("t6_busy_pre", by_o[0], 1);
      rst = 1'b1;
      #1;
      snap();
      check("t6_cx", cx_o[0], 320);
      check("t6_cy", cy_o[0], 240);
      check("t6_busy", by_o[0], 0);
      check("t6_done", dn_o[0], 0);
      mdl_reset();
      vs = 1'b1;
      seen = 0;
      repeat (4) begin @(negedge clk); snap(); seen += dn_o[0]; end
      rst = 1'b0;
      repeat (4) begin @(negedge clk); snap(); seen += dn_o[0]; end
      check("t6_nodone", seen, 0);
      check_state("t6_idle");
      frame(1'b0, -1);
      check("t6_after", cx_o[0], 321);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
